// File: rtl/seven_seg_scan_driver_if.sv
// Signal bundle between the display controller and the seven-segment scan driver.
// The controller side uses master, the scan driver uses slave.
interface seven_seg_scan_driver_if;
    logic [15:0] digitValues;
    logic        loadStrobe;
    logic [3:0]  enableMask;
    logic [3:0]  digitSelect;
    logic [3:0]  digitValue;
    logic [1:0]  digitIndex;
    logic        frameStart;

    modport master (
        output digitValues, loadStrobe, enableMask,
        input  digitSelect, digitValue, digitIndex, frameStart
    );

    modport slave (
        input  digitValues, loadStrobe, enableMask,
        output digitSelect, digitValue, digitIndex, frameStart
    );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit scan generator with per-slot blanking and
// frame-synchronous double-buffered display values.
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    resetN,
    seven_seg_scan_driver_if.slave  bus
);
    localparam int             CW         = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  LAST_CNT   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]  BLANK_END  = CW'(BLANK_CYCLES);
    localparam bit             BLANK_ZERO = (BLANK_CYCLES == 0);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     idx_q, idx_d;
    logic [15:0]    shadow_q, active_q, active_d;
    logic           pending_q;
    logic [3:0]     sel_q, val_q;
    logic           frame_q;
    logic           wrap, boundary;

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wrap     = (cnt_q == LAST_CNT);
        boundary = wrap && (idx_q == 2'd3);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        idx_d    = wrap ? idx_q + 2'd1 : idx_q;
        active_d = (boundary && pending_q) ? shadow_q : active_q;

        state_d = state_q;
        case (state_q)
            BLANK: if (BLANK_ZERO || cnt_d == BLANK_END) state_d = ON;
            ON:    if (wrap && !BLANK_ZERO)              state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the value buffers are reset too, so the first frame after reset shows zeros rather than stale data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            active_q <= active_d;
            // A strobe on the boundary cycle wins: its data must survive until the next boundary.
            if (bus.loadStrobe) begin
                shadow_q  <= bus.digitValues;
                pending_q <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
        end
    end

    // Outputs are computed from next-state so they line up with the counter/state registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sel_q   <= '0;
            val_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            sel_q   <= (state_d == ON) ? ((4'b0001 << idx_d) & bus.enableMask) : 4'b0000;
            frame_q <= boundary;
            if (wrap) val_q <= active_d[{idx_d, 2'b00} +: 4];
        end
    end

    assign bus.digitSelect = sel_q;
    assign bus.digitValue  = val_q;
    assign bus.digitIndex  = idx_q;
    assign bus.frameStart  = frame_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with REFRESH_DIV = 8: a blanked
// instance (BLANK_CYCLES = 2) and a zero-blank instance (BLANK_CYCLES = 0).
module tb_seven_seg_scan_driver;
    logic clk;
    logic resetN;
    int   checks = 0;
    int   errors = 0;
    int   pos;

    seven_seg_scan_driver_if bus ();
    seven_seg_scan_driver_if bus0 ();

    seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .resetN(resetN), .bus(bus.slave)
    );

    seven_seg_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .resetN(resetN), .bus(bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       frame;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @pos %0d: got %h expected %h", name, pos, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % 32;
    endtask

    task automatic goto_pos(input int p);
        step();
        while (pos != p) step();
    endtask

    task automatic strobe(input logic [15:0] v);
        bus.digitValues = v;
        bus.loadStrobe  = 1'b1;
        step();
        bus.loadStrobe  = 1'b0;
    endtask

    initial begin
        vec_t scan [11];
        logic [3:0] exp_sel;
        bit first;

        scan[0]  = '{2, 4'b0000, 2'd0, 1'b0};
        scan[1]  = '{6, 4'b0001, 2'd0, 1'b0};
        scan[2]  = '{2, 4'b0000, 2'd1, 1'b0};
        scan[3]  = '{6, 4'b0010, 2'd1, 1'b0};
        scan[4]  = '{2, 4'b0000, 2'd2, 1'b0};
        scan[5]  = '{6, 4'b0100, 2'd2, 1'b0};
        scan[6]  = '{2, 4'b0000, 2'd3, 1'b0};
        scan[7]  = '{6, 4'b1000, 2'd3, 1'b0};
        scan[8]  = '{1, 4'b0000, 2'd0, 1'b1};
        scan[9]  = '{1, 4'b0000, 2'd0, 1'b0};
        scan[10] = '{6, 4'b0001, 2'd0, 1'b0};

        resetN           = 1'b0;
        bus.digitValues  = '0;
        bus.loadStrobe   = 1'b0;
        bus.enableMask   = 4'b1111;
        bus0.digitValues = '0;
        bus0.loadStrobe  = 1'b0;
        bus0.enableMask  = 4'b1111;
        pos              = 0;
        repeat (3) @(posedge clk);
        #4 resetN = 1'b1;

        // Reset state and full scan of one frame plus the start of the next
        first = 1'b1;
        foreach (scan[k]) begin
            for (int j = 0; j < scan[k].n; j++) begin
                if (!first) step();
                first = 1'b0;
                check($sformatf("scan_sel[%0d]", k), 16'(bus.digitSelect), 16'(scan[k].sel));
                check($sformatf("scan_idx[%0d]", k), 16'(bus.digitIndex), 16'(scan[k].idx));
                check($sformatf("scan_frame[%0d]", k), 16'(bus.frameStart), 16'(scan[k].frame));
                check($sformatf("scan_val[%0d]", k), 16'(bus.digitValue), 16'h0);
            end
        end

        // Strobe mid-frame: values appear only from the next frame
        goto_pos(10);
        strobe(16'h4321);
        check("db_hold_s1", 16'(bus.digitValue), 16'h0);
        goto_pos(16); check("db_hold_s2", 16'(bus.digitValue), 16'h0);
        goto_pos(24); check("db_hold_s3", 16'(bus.digitValue), 16'h0);
        goto_pos(0);  check("db_new_s0", 16'(bus.digitValue), 16'h1);
        check("db_frame", 16'(bus.frameStart), 16'h1);
        goto_pos(8);  check("db_new_s1", 16'(bus.digitValue), 16'h2);
        goto_pos(16); check("db_new_s2", 16'(bus.digitValue), 16'h3);
        goto_pos(24); check("db_new_s3", 16'(bus.digitValue), 16'h4);
        goto_pos(31); check("db_hold_end", 16'(bus.digitValue), 16'h4);
        check("db_sel_end", 16'(bus.digitSelect), 16'h8);

        // Strobe on the wrap cycle: old values persist for one more frame
        strobe(16'hABCD);
        check("co_s0_old", 16'(bus.digitValue), 16'h1);
        check("co_frame", 16'(bus.frameStart), 16'h1);
        goto_pos(8);  check("co_s1_old", 16'(bus.digitValue), 16'h2);
        goto_pos(16); check("co_s2_old", 16'(bus.digitValue), 16'h3);
        goto_pos(24); check("co_s3_old", 16'(bus.digitValue), 16'h4);
        goto_pos(0);  check("co_s0_new", 16'(bus.digitValue), 16'hD);
        goto_pos(8);  check("co_s1_new", 16'(bus.digitValue), 16'hC);
        step();       check("co_s1_blank_val", 16'(bus.digitValue), 16'hC);
        check("co_s1_blank_sel", 16'(bus.digitSelect), 16'h0);
        goto_pos(16); check("co_s2_new", 16'(bus.digitValue), 16'hB);
        goto_pos(24); check("co_s3_new", 16'(bus.digitValue), 16'hA);

        // Two strobes in one frame: the last one wins
        goto_pos(12);
        strobe(16'h1111);
        strobe(16'h5678);
        goto_pos(0); check("lw_s0", 16'(bus.digitValue), 16'h8);
        goto_pos(8); check("lw_s1", 16'(bus.digitValue), 16'h7);

        // Masking: dark slots keep their time, frame period stays 32
        goto_pos(0);
        bus.enableMask = 4'b0101;
        for (int i = 0; i < 32; i++) begin
            step();
            exp_sel = ((pos % 8) >= 2) ? ((4'b0001 << (pos / 8)) & 4'b0101) : 4'b0000;
            check("mask_sel", 16'(bus.digitSelect), 16'(exp_sel));
            check("mask_frame", 16'(bus.frameStart), (pos == 0) ? 16'h1 : 16'h0);
        end

        // Mask change lands one cycle later
        goto_pos(3);
        check("mask_pre", 16'(bus.digitSelect), 16'h1);
        bus.enableMask = 4'b0000;
        step(); check("mask_off", 16'(bus.digitSelect), 16'h0);
        bus.enableMask = 4'b1111;
        step(); check("mask_on", 16'(bus.digitSelect), 16'h1);

        // Asynchronous reset in the middle of slot 2's ON window
        goto_pos(20);
        check("pre_rst_sel", 16'(bus.digitSelect), 16'h4);
        check("pre_rst_val", 16'(bus.digitValue), 16'h6);
        #3 resetN = 1'b0;
        #1;
        check("arst_sel", 16'(bus.digitSelect), 16'h0);
        check("arst_val", 16'(bus.digitValue), 16'h0);
        check("arst_idx", 16'(bus.digitIndex), 16'h0);
        check("arst_frame", 16'(bus.frameStart), 16'h0);
        @(posedge clk);
        #4 resetN = 1'b1;
        pos = 0;
        check("rel_sel0", 16'(bus.digitSelect), 16'h0);

        // Restart of both instances; the zero-blank one never goes dark
        for (int i = 0; i < 16; i++) begin
            step();
            exp_sel = ((pos % 8) >= 2) ? (4'b0001 << (pos / 8)) : 4'b0000;
            check("rst_sel", 16'(bus.digitSelect), 16'(exp_sel));
            check("rst_val", 16'(bus.digitValue), 16'h0);
            check("rst_idx", 16'(bus.digitIndex), 16'(pos / 8));
            check("zb_sel", 16'(bus0.digitSelect), 16'(4'b0001 << (pos / 8)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed scan generator for the 4-digit seven-segment display.
- Produces the active-high one-hot digit-select word that the downstream digit selector inverts into active-low anode enables.
- Presents the 4-bit value of the currently lit digit for the segment decoder.
- Adds an inter-digit blanking window against ghosting, and frame-synchronous double-buffering of display values so a digit never changes mid-frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all digits off; legal range 0 .. REFRESH_DIV-1.

Ports:
- clk  input  1  system clock; all state on the rising edge.
- resetN  input  1  asynchronous active-low reset.
- digitValues  input  16  new display values; nibble k ([4k+3:4k]) belongs to digit k.
- loadStrobe  input  1  one-cycle strobe; captures digitValues into the shadow buffer.
- enableMask  input  4  per-digit enable; bit k = 0 keeps digit k dark during its slot.
- digitSelect  output  4  one-hot active-high digit select; all zero while blanking.
- digitValue  output  4  value for the digit currently being scanned.
- digitIndex  output  2  index of the current slot.
- frameStart  output  1  one-cycle pulse at each wrap from slot 3 to slot 0.

Behaviour:
- Reset (resetN low, asynchronous): the following are all cleared to 0:
  - slot counter, digitIndex, state (BLANK);
  - shadow buffer, active buffer, pending flag;
  - digitSelect, digitValue, frameStart.
  - Reset mid-slot abandons the slot immediately.
  - The first slot after release is slot 0, starting with a full blanking window.
- Slot counter: counts 0 .. REFRESH_DIV-1 and wraps to 0.
  - On wrap, digitIndex increments modulo 4 (3 -> 0).
- State machine (two states):
  - BLANK: entered when the counter reaches 0; digitSelect = 0.
  - BLANK -> ON when the counter reaches BLANK_CYCLES.
  - ON -> BLANK on counter wrap.
  - BLANK_CYCLES = 0: BLANK never occupies a cycle; the slot is ON throughout.
- ON output: digitSelect = (1 << digitIndex) AND enableMask.
  - enableMask is sampled every cycle, so a mask change takes effect one cycle later.
  - A masked digit keeps its slot time; it is dark, not skipped.
- All outputs are registered: they reflect counter/state/index with one clock of latency relative to the internal next-state.
- digitValue: loads active[digitIndex] on the first cycle of each slot and holds for the whole slot, including the blanking window.
- digitIndex: changes only at slot boundaries.
- Double buffer:
  - loadStrobe high: shadow <= digitValues, pending <= 1.
  - Frame boundary (counter wrap with digitIndex = 3): if pending, active <= shadow and pending <= 0; otherwise active is unchanged. frameStart pulses high for exactly one cycle, the first cycle of the new slot 0.
  - loadStrobe on the same cycle as the boundary: the boundary commits the shadow contents from before this cycle. The strobe data lands in shadow, pending stays 1, and it commits at the next boundary.
  - Repeated strobes within a frame: last one wins.
- digitSelect is never multi-hot.
- digitSelect is zero on every cycle where digitIndex changes, provided BLANK_CYCLES >= 1.

Test Plan (REFRESH_DIV = 8, BLANK_CYCLES = 2):
- Reset/scan: release reset, enableMask = 4'b1111 -> digitSelect = 0 for 2 cycles, then 4'b0001 for 6 cycles. Then 0 for 2 cycles, then 4'b0010, and so on through 4'b1000. frameStart pulses once every 32 cycles, at the first cycle of slot 0.
- Double buffer: during slot 1, loadStrobe with digitValues = 16'h4321 -> digitValue stays 0 for the rest of the frame. From the next slot 0, digitValue = 1, 2, 3, 4 in slots 0..3.
- Coincident strobe: loadStrobe with 16'hABCD exactly on the slot-3 -> slot-0 wrap cycle -> the old values persist for the whole next frame. 4'hD appears in slot 0 of the frame after that.
- Masking: enableMask = 4'b0101 -> digitSelect cycles 0001, 0000, 0100, 0000 (each after its blank window). Slot timing and frameStart period are unchanged (32 cycles).
- Async reset mid-ON: assert resetN low in slot 2 between clock edges -> digitSelect, digitValue, digitIndex and frameStart go to 0 immediately, without a clock edge. After release, the scan restarts at slot 0 with 2 blank cycles and active values 0.
- Zero blank: BLANK_CYCLES = 0 -> digitSelect is nonzero on every cycle with all digits enabled, and advances 0001 -> 0010 directly at the wrap.
